// File: rtl/vrf_pkg.sv
// rtl/vrf_pkg.sv - shared types and constants for the vector register file read path
package vrf_pkg;

    localparam int VrfNumWords  = 1024;
    localparam int VrfDataWidth = 64;
    localparam int VrfMaxLen    = 64;
    localparam int VrfAddrWidth = (VrfNumWords > 1) ? $clog2(VrfNumWords) : 1;
    localparam int VrfLenWidth  = $clog2(VrfMaxLen + 1);

    typedef logic [VrfAddrWidth-1:0] vrf_addr_t;
    typedef logic [VrfDataWidth-1:0] vrf_data_t;
    typedef logic [VrfLenWidth-1:0]  vrf_len_t;

    typedef struct packed {
        vrf_addr_t addr;
        vrf_len_t  len;
    } vrf_rd_req_t;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_e;

    function automatic logic is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vrf_reader_fifo.sv
// rtl/vrf_reader_fifo.sv - 2-entry FIFO with registered head, flush and full/empty flags
module vrf_reader_fifo #(
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);
    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/vrf_operand_reader.sv
// rtl/vrf_operand_reader.sv - burst reader walking VRF addresses into a valid/ready word stream
module vrf_operand_reader
    import vrf_pkg::*;
#(
    parameter int NumWords  = VrfNumWords,
    parameter int DataWidth = VrfDataWidth,
    parameter int MaxLen    = VrfMaxLen,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int LenWidth  = $clog2(MaxLen + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic                 flush_i,
    output logic [AddrWidth-1:0] vrf_raddr_o,
    input  logic [DataWidth-1:0] vrf_rdata_i,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_last_o,
    output logic                 busy_o
);
    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 last;
    } entry_t;

    if (!is_pow2(NumWords)) begin : g_num_words_not_pow2
        $error("vrf_operand_reader: NumWords must be a power of two");
    end

    rd_state_e            state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [LenWidth-1:0]  remaining_q, remaining_d;
    logic                 fifo_full, fifo_empty;
    logic                 pop, fire;
    entry_t               head, push_entry;

    // A full FIFO still accepts a read when its head leaves in the same cycle.
    assign pop        = !fifo_empty && data_ready_i;
    assign fire       = (state_q == RD_READ) && !flush_i && (!fifo_full || pop);
    assign push_entry = '{data: vrf_rdata_i, last: (remaining_q == LenWidth'(1))};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (flush_i) begin
            state_d = RD_IDLE;
        end else if (state_q == RD_IDLE) begin
            if (req_valid_i && (req_len_i != '0)) begin
                addr_d      = req_addr_i;
                remaining_d = req_len_i;
                state_d     = RD_READ;
            end
        end else if (fire) begin
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == LenWidth'(1)) begin
                state_d = RD_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    vrf_reader_fifo #(
        .entry_t(entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_i     (fire),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign req_ready_o  = (state_q == RD_IDLE) && !flush_i;
    assign vrf_raddr_o  = addr_q;
    assign data_valid_o = !fifo_empty;
    assign data_o       = head.data;
    assign data_last_o  = head.last && !fifo_empty;
    assign busy_o       = (state_q == RD_READ) || !fifo_empty;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_valid_i |-> (req_len_i <= LenWidth'(MaxLen)));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (data_valid_o && !data_ready_i && !flush_i) |=> $stable(data_o));

endmodule

// File: tb/tb_vrf_operand_reader.sv
// tb/tb_vrf_operand_reader.sv - self-checking bench for vrf_operand_reader
module tb_vrf_operand_reader;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          flush;
    logic [AW-1:0] vrf_raddr;
    logic [DW-1:0] vrf_rdata;
    logic          data_valid, data_ready, data_last, busy;
    logic [DW-1:0] data;

    logic [DW-1:0] ram [1024];
    int            vectors;
    int            errors;

    always #5 clk = ~clk;
    assign vrf_rdata = ram[vrf_raddr];

    vrf_operand_reader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .flush_i     (flush),
        .vrf_raddr_o (vrf_raddr),
        .vrf_rdata_i (vrf_rdata),
        .data_valid_o(data_valid),
        .data_ready_i(data_ready),
        .data_o      (data),
        .data_last_o (data_last),
        .busy_o      (busy)
    );

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; flush = 0; data_ready = 0; req_addr = '0; req_len = '0;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({req_ready, data_valid, data_last, busy} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got %b exp 1000", {req_ready, data_valid, data_last, busy});
        end
        vectors++;
        if (vrf_raddr !== '0 || data !== '0) begin
            errors++; $display("FAIL reset_values got raddr %0d data %h exp 0 0", vrf_raddr, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 1024; i++) ram[i] = DW'(i * 3);
        @(negedge clk);
        req_valid = 1; req_addr = 10; req_len = 4; data_ready = 1; flush = 0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_req_ready got %b exp 1", req_ready); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            if (c <= 4) begin
                vectors++;
                if (vrf_raddr !== AW'(10 + c - 1)) begin
                    errors++; $display("FAIL basic_raddr c%0d got %0d exp %0d", c, vrf_raddr, 10 + c - 1);
                end
            end
            if (c >= 2 && c <= 5) begin
                vectors++;
                if (data_valid !== 1'b1 || data !== DW'((10 + c - 2) * 3) || data_last !== (c == 5)) begin
                    errors++; $display("FAIL basic_data c%0d got v%b %0d l%b exp v1 %0d l%b",
                                       c, data_valid, data, data_last, (10 + c - 2) * 3, (c == 5));
                end
            end
            vectors++;
            if (busy !== (c <= 5) || (c == 6 && data_valid !== 1'b0)) begin
                errors++; $display("FAIL basic_busy c%0d got busy %b valid %b exp busy %b", c, busy, data_valid, (c <= 5));
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 1024; i++) ram[i] = DW'(i * 3);
        @(negedge clk);
        req_valid = 1; req_addr = 10; req_len = 4; data_ready = 0; flush = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 0;
            data_ready = (c >= 6);
            #1;
            if (c >= 3 && c <= 5) begin
                vectors++;
                if (vrf_raddr !== AW'(12)) begin errors++; $display("FAIL bp_raddr_hold c%0d got %0d exp 12", c, vrf_raddr); end
            end
            if (c >= 2 && c <= 5) begin
                vectors++;
                if (data_valid !== 1'b1 || data !== DW'(30) || data_last !== 1'b0) begin
                    errors++; $display("FAIL bp_stall_data c%0d got v%b %0d l%b exp v1 30 l0", c, data_valid, data, data_last);
                end
            end
            if (c >= 6 && c <= 9) begin
                vectors++;
                if (data_valid !== 1'b1 || data !== DW'((10 + c - 6) * 3) || data_last !== (c == 9)) begin
                    errors++; $display("FAIL bp_drain c%0d got v%b %0d l%b exp v1 %0d l%b",
                                       c, data_valid, data, data_last, (10 + c - 6) * 3, (c == 9));
                end
            end
            if (c == 10) begin
                vectors++;
                if (busy !== 1'b0 || data_valid !== 1'b0) begin
                    errors++; $display("FAIL bp_idle got busy %b valid %b exp 0 0", busy, data_valid);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] a;
        for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1; req_addr = 1022; req_len = 4; data_ready = 1; flush = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            if (c <= 4) begin
                a = AW'(1022 + c - 1);
                vectors++;
                if (vrf_raddr !== a) begin errors++; $display("FAIL wrap_raddr c%0d got %0d exp %0d", c, vrf_raddr, a); end
            end
            if (c >= 2) begin
                a = AW'(1022 + c - 2);
                vectors++;
                if (data_valid !== 1'b1 || data !== ram[a] || data_last !== (c == 5)) begin
                    errors++; $display("FAIL wrap_data c%0d got v%b %h l%b exp v1 %h l%b",
                                       c, data_valid, data, data_last, ram[a], (c == 5));
                end
            end
        end
    endtask

    task automatic test_zero_back_to_back();
        logic [DW:0]   exp_q[$];
        logic [DW:0]   exp;
        logic [AW-1:0] a;
        int            n;
        for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1; req_addr = 7; req_len = 0; data_ready = 1; flush = 0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL zero_req_ready got %b exp 1", req_ready); end
        @(negedge clk);
        req_valid = 1; req_addr = 5; req_len = 2; data_ready = 0;
        #1;
        vectors++;
        if (busy !== 1'b0 || data_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL zero_no_beats got busy %b valid %b ready %b exp 0 0 1", busy, data_valid, req_ready);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            vectors++;
            if (vrf_raddr !== AW'(4 + c)) begin errors++; $display("FAIL b2b_raddr c%0d got %0d exp %0d", c, vrf_raddr, 4 + c); end
        end
        a = AW'($urandom);
        n = $urandom_range(1, 4);
        exp_q.push_back({ram[5], 1'b0});
        exp_q.push_back({ram[6], 1'b1});
        for (int k = 0; k < n; k++) exp_q.push_back({ram[AW'(int'(a) + k)], (k == n - 1)});
        @(negedge clk);
        req_valid = 1; req_addr = a; req_len = LW'(n); data_ready = 1;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_third_ready got %b exp 1", req_ready); end
        for (int k = 0; k < n + 2; k++) begin
            if (k > 0) begin
                @(negedge clk);
                req_valid = 0;
                #1;
            end
            exp = exp_q.pop_front();
            vectors++;
            if (data_valid !== 1'b1 || {data, data_last} !== exp) begin
                errors++; $display("FAIL b2b_stream k%0d got v%b %h l%b exp v1 %h l%b",
                                   k, data_valid, data, data_last, exp[DW:1], exp[0]);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_end got valid %b busy %b exp 0 0", data_valid, busy);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1; req_addr = 0; req_len = 8; data_ready = 1; flush = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            if (c >= 2) begin
                vectors++;
                if (data_valid !== 1'b1 || data !== ram[c - 2]) begin
                    errors++; $display("FAIL flush_pre c%0d got v%b %h exp v1 %h", c, data_valid, data, ram[c - 2]);
                end
            end
        end
        @(negedge clk);
        flush = 1; req_valid = 1; req_addr = 200; req_len = 1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_req_blocked got %b exp 0", req_ready); end
        @(negedge clk);
        flush = 0; req_valid = 0;
        #1;
        vectors++;
        if (data_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_after got valid %b ready %b busy %b exp 0 1 0", data_valid, req_ready, busy);
        end
        @(negedge clk);
        req_valid = 1; req_addr = 100; req_len = 1;
        @(negedge clk);
        req_valid = 0;
        #1;
        vectors++;
        if (vrf_raddr !== AW'(100)) begin errors++; $display("FAIL flush_new_raddr got %0d exp 100", vrf_raddr); end
        @(negedge clk);
        #1;
        vectors++;
        if (data_valid !== 1'b1 || data !== ram[100] || data_last !== 1'b1) begin
            errors++; $display("FAIL flush_new_data got v%b %h l%b exp v1 %h l1", data_valid, data, data_last, ram[100]);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_new_end got valid %b busy %b exp 0 0", data_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1; req_addr = 0; req_len = 8; data_ready = 0; flush = 0;
        repeat (3) begin
            @(negedge clk);
            req_valid = 0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, data_valid, data_last, busy} !== 4'b1000 || vrf_raddr !== '0 || data !== '0) begin
            errors++; $display("FAIL async_reset got flags %b raddr %0d data %h exp 1000 0 0",
                               {req_ready, data_valid, data_last, busy}, vrf_raddr, data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_random();
        logic [DW:0]   q[$];
        logic [DW:0]   exp;
        logic [DW-1:0] prev_data;
        logic          prev_stall;
        logic          done;
        for (int i = 0; i < 1024; i++) ram[i] = {$urandom, $urandom};
        prev_stall = 0;
        prev_data  = '0;
        flush = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_valid  = ($urandom_range(0, 3) == 0);
            req_addr   = AW'($urandom);
            req_len    = LW'($urandom_range(0, 6));
            data_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                vectors++;
                if (data !== prev_data) begin errors++; $display("FAIL rand_stall c%0d got %h exp %h", c, data, prev_data); end
            end
            if (data_valid && data_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious c%0d got %h exp no word", c, data);
                end else begin
                    exp = q.pop_front();
                    if ({data, data_last} !== exp) begin
                        errors++; $display("FAIL rand_data c%0d got %h l%b exp %h l%b", c, data, data_last, exp[DW:1], exp[0]);
                    end
                end
            end
            if (req_valid && req_ready) begin
                for (int k = 0; k < int'(req_len); k++)
                    q.push_back({ram[AW'(int'(req_addr) + k)], (k == int'(req_len) - 1)});
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = data;
        end
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            req_valid = 0; data_ready = 1;
            #1;
            if (data_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL drain_spurious got %h exp no word", data);
                end else begin
                    exp = q.pop_front();
                    if ({data, data_last} !== exp) begin
                        errors++; $display("FAIL drain_data got %h l%b exp %h l%b", data, data_last, exp[DW:1], exp[0]);
                    end
                end
            end
            done = !busy && (q.size() == 0);
        end
        vectors++;
        if (!done) begin errors++; $display("FAIL drain_timeout got busy %b left %0d exp idle 0", busy, q.size()); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/vrf_operand_reader.md
Name: vrf_operand_reader

Overview:
- Streaming read-side client of the vector register file RAM (asynchronous read, synchronous write, byte-enabled).
- Accepts a burst request (start word address, word count) and walks consecutive addresses on one RAM read port.
- Captures each word into a 2-entry output FIFO and presents it on a valid/ready stream with a last flag.
- Sits between vector issue logic and the lane operand queues; isolates RAM read timing from downstream backpressure.

Parameters:
- NumWords, 1024, words in the RAM array (must match RAM).
- DataWidth, 64, RAM word width.
- MaxLen, 64, max words per request.
- AddrWidth, (NumWords>1)?$clog2(NumWords):1, derived; do not override.
- LenWidth, $clog2(MaxLen+1), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  burst request valid.
- req_ready_o  out  1  reader can accept a request.
- req_addr_i  in  AddrWidth  first word address.
- req_len_i  in  LenWidth  word count, 0..MaxLen.
- flush_i  in  1  abort current burst, drop buffered words.
- vrf_raddr_o  out  AddrWidth  RAM read address (combinational data returns same cycle).
- vrf_rdata_i  in  DataWidth  RAM read data.
- data_valid_o  out  1  output word valid.
- data_ready_i  in  1  consumer accepts word.
- data_o  out  DataWidth  output word.
- data_last_o  out  1  word is final of its burst.
- busy_o  out  1  burst in progress or FIFO non-empty.

Behaviour:
- Reset (async, rst_ni=0): state IDLE, counters 0, FIFO empty.
  - Reset output values: req_ready_o=1, data_valid_o=0, data_last_o=0, busy_o=0, vrf_raddr_o=0, data_o=0.
- States: IDLE, READ.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && len>0: latch addr into addr_q and len into remaining_q; go to READ.
  - On req_valid_i && len==0: handshake completes, no beats, stay IDLE.
- READ:
  - req_ready_o=0. vrf_raddr_o=addr_q.
  - Read fires when the FIFO is not full, or will pop this cycle (data_valid_o && data_ready_i).
  - On fire: push {vrf_rdata_i, remaining_q==1} into the FIFO, addr_q+1, remaining_q-1.
  - If remaining_q==1 on fire: go to IDLE.
- Address arithmetic: addr_q+1 wraps modulo 2^AddrWidth. NumWords must be a power of two; this is checked by an elaboration assertion.
- Latency:
  - Request accepted in cycle 0; first RAM read in cycle 1.
  - Word visible on data_o from cycle 2 (registered FIFO output).
  - With data_ready_i held high, throughput is 1 word/cycle.
- Write/read collision: if the RAM writes the address being read in the same cycle, the pre-write value is captured. The issue logic guarantees ordering; the reader takes no action.
- FIFO:
  - 2 entries; push and pop in the same cycle are allowed when full.
  - data_o, data_last_o and data_valid_o come from the head entry.
  - data_o holds its value while data_valid_o && !data_ready_i.
- Back-to-back bursts: a new request is accepted in the cycle after the last read fires. FIFO contents of the previous burst drain in order, so there is no bubble when the consumer is ready.
- flush_i (highest priority, any state):
  - Next cycle: IDLE, FIFO empty, data_valid_o=0.
  - A request presented in the same cycle as flush_i is not accepted (req_ready_o=0 while flush_i=1).
- Simultaneous flush and pop: the flush wins; the pop is still counted as a completed handshake by the consumer.
- busy_o = (state==READ) || FIFO non-empty.
- Assertions:
  - req_len_i <= MaxLen when req_valid_i.
  - No push when the FIFO is full without a pop.
  - data_o stable under stall.

Decomposition:
- Shared package vrf_pkg holds:
  - vrf_addr_t, vrf_data_t, vrf_len_t typedefs (sized from NumWords/DataWidth/MaxLen constants).
  - vrf_rd_req_t struct {addr, len}.
  - VrfNumWords, VrfDataWidth constants.
- One sub-module: vrf_reader_fifo, a 2-entry FIFO parameterized on the entry type, with full/empty flags and the same clock and reset.

Test Plan:
- Basic burst: addr=10, len=4, RAM[i]=i*3, data_ready_i=1.
  - vrf_raddr_o=10..13 in cycles 1..4.
  - data_o=30,33,36,39 in cycles 2..5; data_last_o only with 39; busy_o falls in cycle 6.
- Backpressure: same burst with data_ready_i low in cycles 2..5.
  - FIFO fills after 2 reads; vrf_raddr_o holds 12 with no further fires.
  - data_o holds 30; after ready rises, 30,33,36,39 are delivered without loss or duplication.
- Wrap: addr=1022, len=4 (NumWords=1024).
  - Reads 1022,1023,0,1; data order preserved; last flag on the word from address 1.
- Zero length and back-to-back: len=0 request, then addr=5 len=2.
  - First request produces no beats; second streams RAM[5],RAM[6] with one last flag.
  - A third request accepted right after the read of 6 streams with no output gap.
- Flush mid-burst: addr=0, len=8, flush_i in cycle 4.
  - Cycle 5: data_valid_o=0, req_ready_o=1, busy_o=0.
  - A new request addr=100 len=1 returns RAM[100] with last=1.
- Async reset mid-burst: drop rst_ni between clock edges during a len=8 burst.
  - All outputs at reset values immediately; after release, a fresh burst behaves as in the basic burst test.
